ita_weight_loader: RTL and testbench
====================================

# ita_weight_loader

- Writer side of the ITA weight-buffer write port. Accepts a narrow stream of weight chunks on a valid/ready handshake and emits one-hot `write_select_t`/`write_data_t` writes.
- Fills one full `weight_t` tile (N×M×WI bits) per N_WRITE_EN accepted beats.
- Sits between the weight DMA/streamer and the ITA weight buffer. Manages a 2-slot (double-buffered) tile credit scheme with the consuming datapath.

## Interface
- N, 16, PE rows per tile
- M, 64, elements per row
- WI, 8, element width
- N_WRITE_EN, 64, write lanes per tile (beats per tile)
- ChunkW (localparam), N*M*WI/N_WRITE_EN = 128, beat width
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous abort/flush
- in_valid_i  in  1  chunk valid
- in_ready_o  out  1  chunk accepted when in_valid_i && in_ready_o
- in_data_i  in  ChunkW  weight chunk, row-major lane order
- wr_slot_o  out  1  destination buffer slot of the current write
- wr_select_o  out  N_WRITE_EN  one-hot lane write enable (`write_select_t`)
- wr_data_o  out  N_WRITE_EN×ChunkW  lane data (`write_data_t`); selected lane = chunk, others 0
- tile_valid_o  out  2  per-slot "tile complete, not yet consumed"
- tile_consume_i  in  1  pulse: oldest valid slot consumed
- rd_slot_o  out  1  slot the consumer reads next
- stall_cnt_o  out  32  backpressure stall counter (see Configuration)

## Operation
- State: beat_cnt [idx_width(N_WRITE_EN)], wr_ptr (1b), rd_ptr (1b), slot_valid[2], registered write outputs.
- FSM:
  - FILL: wr slot free; beats accepted.
  - FULL: `slot_valid[wr_ptr]`=1; in_ready_o=0.
  - FILL→FULL when the last beat completes a tile and the other slot is still valid.
  - FULL→FILL on consume of slot wr_ptr.
- `in_ready_o = !slot_valid[wr_ptr] && !clear_i`. Combinational from registered state only; no path from in_valid_i.
- Accepted beat k (beat_cnt=k):
  - Next cycle: `wr_select_o` has bit k set, lane k of `wr_data_o` = in_data_i, `wr_slot_o` = wr_ptr.
  - Otherwise wr_select_o = 0 and wr_data_o = 0.
  - beat_cnt increments.
- Beat N_WRITE_EN−1 accepted:
  - beat_cnt wraps to 0, wr_ptr toggles.
  - slot_valid[old wr_ptr] sets, becoming visible in the same cycle as the final lane write.
- tile_consume_i:
  - If slot_valid[rd_ptr]: clear it and toggle rd_ptr.
  - If no slot is valid: ignored, no state change.
- Simultaneous tile completion into slot A and consume of slot B: both take effect.
- Completion and consume can never target the same slot in one cycle, because a slot is written only while it is invalid.
- clear_i, priority over all other events:
  - Next cycle: beat_cnt=0, wr_ptr=rd_ptr=0, slot_valid=0, wr_select_o=0.
  - A beat presented during clear_i is not accepted.
- Reset mid-tile discards the partial tile. No partial tile is ever flagged valid.

## Timing
- Reset values: in_ready_o=1, wr_select_o=0, wr_data_o=0, wr_slot_o=0, tile_valid_o=0, rd_slot_o=0, stall_cnt_o=0.
- Latency: accept → lane write is 1 cycle. Last accept → tile_valid_o is 1 cycle.
- Throughput: 1 beat/cycle, so a tile takes N_WRITE_EN cycles.
- Consume → in_ready_o reassert is 1 cycle (one-cycle bubble when FULL).
- in_data_i is sampled only on a handshake. A producer must hold data while in_valid_i && !in_ready_o.

## Configuration
- Macro: `ITA_WEIGHT_LOADER_STALL_CNT_EN`.
- Defined:
  - stall_cnt_o counts cycles with in_valid_i && !in_ready_o.
  - 32-bit saturating at 0xFFFFFFFF.
  - Cleared by reset and clear_i.
- Undefined: the counter is not instantiated and stall_cnt_o is tied to 0.

## Test plan
- Reset release, N_WRITE_EN=64, continuous valid, chunk k = {16{k[7:0]}}:
  - 64 consecutive writes with wr_select_o = 1<<k and lane k = chunk k, at wr_slot_o=0.
  - tile_valid_o=2'b01 in the cycle of the lane-63 write.
- Three tiles back-to-back, no consume:
  - Tiles 0 and 1 fill slots 0 and 1; tile_valid_o=2'b11.
  - in_ready_o=0 from the cycle after tile 1's last accept.
  - Pulse consume: tile_valid_o=2'b10 and rd_slot_o=1; in_ready_o=1 on the next cycle; tile 2 writes slot 0.
- Consume on the same cycle slot 1's last lane completes: slot 0 cleared and slot 1 set; tile_valid_o=2'b10.
- tile_consume_i with tile_valid_o=0: no change to rd_slot_o or tile_valid_o.
- clear_i at beat 30 of tile 0:
  - Next cycle wr_select_o=0 and tile_valid_o=0.
  - A subsequent tile restarts at lane 0 in slot 0.
  - With `ITA_WEIGHT_LOADER_STALL_CNT_EN`: holding valid 10 cycles while FULL gives stall_cnt_o=10; after clear_i it reads 0.
- rst_ni asserted mid-tile (asynchronous, between clock edges): all outputs at reset values immediately. The first beat after release writes lane 0.

Source files
------------

// File: rtl/ita_weight_loader.sv
// Writer side of the ITA weight-buffer port: turns a chunk stream into one-hot lane writes
// over a double-buffered tile pair. Optional stall counter: ITA_WEIGHT_LOADER_STALL_CNT_EN.
module ita_weight_loader #(
   parameter  int unsigned N          = 16,
   parameter  int unsigned M          = 64,
   parameter  int unsigned WI         = 8,
   parameter  int unsigned N_WRITE_EN = 64,
   localparam int unsigned ChunkW     = N * M * WI / N_WRITE_EN,
   localparam int unsigned IdxW       = (N_WRITE_EN > 1) ? $clog2(N_WRITE_EN) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clear_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [ChunkW-1:0]            in_data_i,
   output logic                         wr_slot_o,
   output logic [N_WRITE_EN-1:0]        wr_select_o,
   output logic [N_WRITE_EN*ChunkW-1:0] wr_data_o,
   output logic [1:0]                   tile_valid_o,
   input  logic                         tile_consume_i,
   output logic                         rd_slot_o,
   output logic [31:0]                  stall_cnt_o
);

   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] beat_cnt_q;
   logic            wr_ptr_q, wr_ptr_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic [1:0]      slot_valid_q, slot_valid_d;
   logic            accept, last_beat, consume;

   // Ready depends only on registered state and clear, never on in_valid_i.
   assign in_ready_o = (state_q == FILL) && !clear_i;
   assign accept     = in_valid_i && in_ready_o;
   assign last_beat  = accept && (beat_cnt_q == IdxW'(N_WRITE_EN - 1));
   assign consume    = tile_consume_i && slot_valid_q[rd_ptr_q];

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
      slot_valid_d = slot_valid_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      if (last_beat) begin
         slot_valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d               = ~wr_ptr_q;
      end
      // Completion and consume never hit the same slot: the slot being filled is invalid.
      if (consume) begin
         slot_valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d               = ~rd_ptr_q;
      end
      state_d = slot_valid_d[wr_ptr_d] ? FULL : FILL;
   end

   // NOTE: the wide lane-data register is reset too, because its value is visible on the port.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= FILL;
         beat_cnt_q   <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         slot_valid_q <= '0;
         wr_slot_o    <= 1'b0;
         wr_select_o  <= '0;
         wr_data_o    <= '0;
      end else if (clear_i) begin
         state_q      <= FILL;
         beat_cnt_q   <= '0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         slot_valid_q <= '0;
         wr_slot_o    <= 1'b0;
         wr_select_o  <= '0;
         wr_data_o    <= '0;
      end else begin
         // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         slot_valid_q <= slot_valid_d;
         for (int i = 0; i < N_WRITE_EN; i++) begin
            wr_select_o[i]                <= accept && (beat_cnt_q == IdxW'(i));
            wr_data_o[i*ChunkW +: ChunkW] <= (accept && (beat_cnt_q == IdxW'(i))) ? in_data_i : '0;
         end
         if (accept) begin
            wr_slot_o  <= wr_ptr_q;
            beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
         end
      end
   end

   assign tile_valid_o = slot_valid_q;
   assign rd_slot_o    = rd_ptr_q;

`ifdef ITA_WEIGHT_LOADER_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
      end else if (clear_i) begin
         stall_cnt_q <= '0;
      end else if (in_valid_i && !in_ready_o && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ita_weight_loader.sv
// Self-checking bench for ita_weight_loader: directed scenarios plus randomized traffic
// against a tile-count model (tiles completed / consumed / beats into the current tile).
module tb_ita_weight_loader;
   localparam int NW = 64;
   localparam int CW = 128;
   localparam int DW = NW * CW;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          clear_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [CW-1:0] in_data_i;
   logic          wr_slot_o;
   logic [NW-1:0] wr_select_o;
   logic [DW-1:0] wr_data_o;
   logic [1:0]    tile_valid_o;
   logic          tile_consume_i;
   logic          rd_slot_o;
   logic [31:0]   stall_cnt_o;

   ita_weight_loader dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .in_data_i      (in_data_i),
      .wr_slot_o      (wr_slot_o),
      .wr_select_o    (wr_select_o),
      .wr_data_o      (wr_data_o),
      .tile_valid_o   (tile_valid_o),
      .tile_consume_i (tile_consume_i),
      .rd_slot_o      (rd_slot_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: tile counts plus expected registered write outputs.
   int            m_done, m_cons, m_beats;
   logic          exp_ready, obs_ready, exp_slot;
   logic [31:0]   exp_stall;
   logic [NW-1:0] exp_sel;
   logic [DW-1:0] exp_data;

   function automatic logic [1:0] model_tv();
      logic [1:0] tv = 2'b00;
      for (int k = m_cons; k < m_done; k++) tv[k % 2] = 1'b1;
      return tv;
   endfunction

   function automatic logic model_rd();
      return 1'(m_cons % 2);
   endfunction

   function automatic int lane_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
      for (int i = 0; i < NW; i++) if (a[i*CW +: CW] !== b[i*CW +: CW]) return i;
      return 0;
   endfunction

   function automatic logic [CW-1:0] rnd_chunk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_done = 0; m_cons = 0; m_beats = 0;
      exp_stall = '0; exp_sel = '0; exp_data = '0; exp_slot = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model, and land 1 ns after the edge.
   task automatic run_cycle(input logic v, input logic [CW-1:0] d, input logic c, input logic cl);
      int   pend;
      logic acc;
      in_valid_i = v; in_data_i = d; tile_consume_i = c; clear_i = cl;
      #1;
      obs_ready = in_ready_o;
      pend      = m_done - m_cons;
      exp_ready = !cl && (pend < 2);
      acc       = v && exp_ready;
      exp_sel   = '0;
      exp_data  = '0;
      if (cl) begin
         m_done = 0; m_cons = 0; m_beats = 0; exp_stall = '0;
      end else begin
`ifdef ITA_WEIGHT_LOADER_STALL_CNT_EN
         if (v && !exp_ready && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
`endif
         if (acc) begin
            exp_sel[m_beats]             = 1'b1;
            exp_data[m_beats*CW +: CW]   = d;
            exp_slot                     = 1'(m_done % 2);
            m_beats++;
            if (m_beats == NW) begin
               m_beats = 0;
               m_done++;
            end
         end
         if (c && pend > 0) m_cons++;
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; clear_i = 0; in_valid_i = 0; in_data_i = '0; tile_consume_i = 0;
      #12;
      checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
      checks++; if (wr_select_o !== '0) begin failures++; $display("FAIL reset_sel got=%h exp=0", wr_select_o); end
      checks++; if (wr_data_o !== '0) begin failures++; $display("FAIL reset_data lane=%0d nonzero", lane_diff(wr_data_o, '0)); end
      checks++; if (wr_slot_o !== 1'b0) begin failures++; $display("FAIL reset_slot got=%b exp=0", wr_slot_o); end
      checks++; if (tile_valid_o !== 2'b00) begin failures++; $display("FAIL reset_tv got=%b exp=00", tile_valid_o); end
      checks++; if (rd_slot_o !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", rd_slot_o); end
      checks++; if (stall_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt_o); end
      rst_ni = 1'b1;
      model_reset();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_fill_tile();
      logic [7:0] kb;
      for (int k = 0; k < NW; k++) begin
         kb = k[7:0];
         run_cycle(1'b1, {16{kb}}, 1'b0, 1'b0);
         checks++; if (wr_select_o !== exp_sel) begin failures++; $display("FAIL fill_sel k=%0d got=%h exp=%h", k, wr_select_o, exp_sel); end
         checks++; if (wr_data_o !== exp_data) begin failures++; $display("FAIL fill_data k=%0d lane=%0d got=%h exp=%h", k, lane_diff(wr_data_o, exp_data), wr_data_o[lane_diff(wr_data_o, exp_data)*CW +: CW], exp_data[lane_diff(wr_data_o, exp_data)*CW +: CW]); end
         checks++; if (wr_slot_o !== exp_slot) begin failures++; $display("FAIL fill_slot k=%0d got=%b exp=%b", k, wr_slot_o, exp_slot); end
         checks++; if (tile_valid_o !== model_tv()) begin failures++; $display("FAIL fill_tv k=%0d got=%b exp=%b", k, tile_valid_o, model_tv()); end
      end
   endtask

   task automatic test_back_to_back();
      logic [CW-1:0] d;
      for (int k = 0; k < NW; k++) begin
         run_cycle(1'b1, rnd_chunk(), 1'b0, 1'b0);
         checks++; if (wr_slot_o !== exp_slot || wr_select_o !== exp_sel) begin failures++; $display("FAIL b2b_write k=%0d got=%b/%h exp=%b/%h", k, wr_slot_o, wr_select_o, exp_slot, exp_sel); end
      end
      checks++; if (tile_valid_o !== model_tv()) begin failures++; $display("FAIL b2b_tv_full got=%b exp=%b", tile_valid_o, model_tv()); end
      d = rnd_chunk();
      for (int k = 0; k < 10; k++) begin
         run_cycle(1'b1, d, 1'b0, 1'b0);
         checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL b2b_ready_full k=%0d got=%b exp=%b", k, obs_ready, exp_ready); end
      end
      checks++; if (stall_cnt_o !== exp_stall) begin failures++; $display("FAIL b2b_stall got=%0d exp=%0d", stall_cnt_o, exp_stall); end
      run_cycle(1'b1, d, 1'b1, 1'b0);
      checks++; if (tile_valid_o !== model_tv()) begin failures++; $display("FAIL b2b_tv_consume got=%b exp=%b", tile_valid_o, model_tv()); end
      checks++; if (rd_slot_o !== model_rd()) begin failures++; $display("FAIL b2b_rd_consume got=%b exp=%b", rd_slot_o, model_rd()); end
      run_cycle(1'b1, d, 1'b0, 1'b0);
      checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL b2b_ready_after got=%b exp=%b", obs_ready, exp_ready); end
      checks++; if (wr_select_o !== exp_sel || wr_slot_o !== exp_slot) begin failures++; $display("FAIL b2b_tile2 got=%b/%h exp=%b/%h", wr_slot_o, wr_select_o, exp_slot, exp_sel); end
   endtask

   task automatic test_clear();
      run_cycle(1'b0, '0, 1'b0, 1'b1);
      checks++; if (stall_cnt_o !== exp_stall) begin failures++; $display("FAIL clear_stall got=%0d exp=%0d", stall_cnt_o, exp_stall); end
      for (int k = 0; k < 30; k++) run_cycle(1'b1, rnd_chunk(), 1'b0, 1'b0);
      run_cycle(1'b1, rnd_chunk(), 1'b0, 1'b1);
      checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL clear_ready got=%b exp=%b", obs_ready, exp_ready); end
      checks++; if (wr_select_o !== exp_sel) begin failures++; $display("FAIL clear_sel got=%h exp=%h", wr_select_o, exp_sel); end
      checks++; if (tile_valid_o !== model_tv()) begin failures++; $display("FAIL clear_tv got=%b exp=%b", tile_valid_o, model_tv()); end
      run_cycle(1'b1, rnd_chunk(), 1'b0, 1'b0);
      checks++; if (wr_select_o !== exp_sel || wr_slot_o !== exp_slot) begin failures++; $display("FAIL clear_restart got=%b/%h exp=%b/%h", wr_slot_o, wr_select_o, exp_slot, exp_sel); end
      checks++; if (wr_data_o !== exp_data) begin failures++; $display("FAIL clear_restart_data lane=%0d", lane_diff(wr_data_o, exp_data)); end
   endtask

   task automatic test_consume_on_completion();
      run_cycle(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 2 * NW - 1; k++) run_cycle(1'b1, rnd_chunk(), 1'b0, 1'b0);
      run_cycle(1'b1, rnd_chunk(), 1'b1, 1'b0);
      checks++; if (tile_valid_o !== model_tv()) begin failures++; $display("FAIL coc_tv got=%b exp=%b", tile_valid_o, model_tv()); end
      checks++; if (rd_slot_o !== model_rd()) begin failures++; $display("FAIL coc_rd got=%b exp=%b", rd_slot_o, model_rd()); end
      checks++; if (wr_slot_o !== exp_slot) begin failures++; $display("FAIL coc_slot got=%b exp=%b", wr_slot_o, exp_slot); end
   endtask

   task automatic test_idle_consume();
      run_cycle(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < NW; k++) run_cycle(1'b1, rnd_chunk(), 1'b0, 1'b0);
      run_cycle(1'b0, '0, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         run_cycle(1'b0, '0, 1'b1, 1'b0);
         checks++; if (rd_slot_o !== model_rd()) begin failures++; $display("FAIL idle_rd k=%0d got=%b exp=%b", k, rd_slot_o, model_rd()); end
         checks++; if (tile_valid_o !== model_tv()) begin failures++; $display("FAIL idle_tv k=%0d got=%b exp=%b", k, tile_valid_o, model_tv()); end
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < NW + 10; k++) run_cycle(1'b1, rnd_chunk(), 1'b0, 1'b0);
      in_valid_i = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b exp=1", in_ready_o); end
      checks++; if (wr_select_o !== '0 || wr_data_o !== '0 || wr_slot_o !== 1'b0) begin failures++; $display("FAIL arst_write got=%b/%h exp=0/0", wr_slot_o, wr_select_o); end
      checks++; if (tile_valid_o !== 2'b00 || rd_slot_o !== 1'b0) begin failures++; $display("FAIL arst_tiles got=%b/%b exp=00/0", tile_valid_o, rd_slot_o); end
      checks++; if (stall_cnt_o !== 32'd0) begin failures++; $display("FAIL arst_stall got=%0d exp=0", stall_cnt_o); end
      rst_ni = 1'b1;
      model_reset();
      @(posedge clk_i);
      #1;
      run_cycle(1'b1, rnd_chunk(), 1'b0, 1'b0);
      checks++; if (wr_select_o !== exp_sel || wr_slot_o !== exp_slot) begin failures++; $display("FAIL arst_first got=%b/%h exp=%b/%h", wr_slot_o, wr_select_o, exp_slot, exp_sel); end
   endtask

   task automatic test_random();
      logic          v, c, cl;
      logic [CW-1:0] d = '0;
      logic          held = 1'b0;
      int            l;
      for (int n = 0; n < 3000; n++) begin
         if (held) v = 1'b1;
         else begin
            v = ($urandom_range(0, 3) != 0);
            d = rnd_chunk();
         end
         c  = ($urandom_range(0, 99) < 2);
         cl = ($urandom_range(0, 499) == 0);
         run_cycle(v, d, c, cl);
         held = v && !obs_ready && !cl;
         checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, obs_ready, exp_ready); end
         checks++; if (wr_select_o !== exp_sel) begin failures++; $display("FAIL rnd_sel n=%0d got=%h exp=%h", n, wr_select_o, exp_sel); end
         checks++; if (wr_data_o !== exp_data) begin failures++; l = lane_diff(wr_data_o, exp_data); $display("FAIL rnd_data n=%0d lane=%0d got=%h exp=%h", n, l, wr_data_o[l*CW +: CW], exp_data[l*CW +: CW]); end
         if (exp_sel != '0) begin
            checks++; if (wr_slot_o !== exp_slot) begin failures++; $display("FAIL rnd_slot n=%0d got=%b exp=%b", n, wr_slot_o, exp_slot); end
         end
         checks++; if (tile_valid_o !== model_tv()) begin failures++; $display("FAIL rnd_tv n=%0d got=%b exp=%b", n, tile_valid_o, model_tv()); end
         checks++; if (rd_slot_o !== model_rd()) begin failures++; $display("FAIL rnd_rd n=%0d got=%b exp=%b", n, rd_slot_o, model_rd()); end
         checks++; if (stall_cnt_o !== exp_stall) begin failures++; $display("FAIL rnd_stall n=%0d got=%0d exp=%0d", n, stall_cnt_o, exp_stall); end
      end
   endtask

   initial begin
      test_reset();
      test_fill_tile();
      test_back_to_back();
      test_clear();
      test_consume_on_completion();
      test_idle_consume();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
